// File: rtl/asic_iocfg_pkg.sv
// Shared types and constants for the pad configuration serialiser.
package asic_iocfg_pkg;

  // Reset configuration word applied to every pad shadow register.
  localparam logic [12:0] DEFCFG_RST = 13'h0403;

  // Gray-ordered so each legal transition flips a single state bit,
  // which keeps decoded ser_* outputs quiet across state changes.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    LOAD  = 2'b11,
    DONE  = 2'b10
  } iocfg_state_e;

  // $clog2 with a floor of one bit, for counters/indices that may be degenerate.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/asic_iocfg_ser.sv
// Serial engine: snapshot shift register, bit-period divider, bit counter
// and ser_* generation. Sequencing is owned by the FSM in the top.
module asic_iocfg_ser
  import asic_iocfg_pkg::*;
#(
  parameter int N   = 8,
  parameter int CW  = 13,
  parameter int DIV = 2
) (
  input  logic              clk,
  input  logic              nreset,
  input  iocfg_state_e      state,
  input  logic              start,
  input  logic [N*CW-1:0]   snap,
  output logic              shift_end,
  output logic              load_end,
  output logic              ser_clk,
  output logic              ser_data,
  output logic              ser_load
);

  localparam int NB = N * CW;
  localparam int BW = $clog2(NB + 1);
  localparam int DW = clog2_min1(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] NB_CNT   = BW'(NB);

  logic [NB-1:0] sreg;
  logic [DW-1:0] div_cnt;
  logic          phase;    // 0: ser_clk low half, 1: ser_clk high half
  logic [BW-1:0] bit_cnt;  // bits still to send, including the current one
  logic          in_shift;
  logic          in_load;
  logic          div_tc;

  assign in_shift = (state == SHIFT);
  assign in_load  = (state == LOAD);
  assign div_tc   = (div_cnt == '0);

  // Divider down-counter walks each half-bit; the shift register advances
  // at the end of the high half. The divider reloads on the final bit so
  // the same count times the LOAD window.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sreg    <= '0;
      div_cnt <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
    end else if (start) begin
      sreg    <= snap;
      div_cnt <= DIV_LAST;
      phase   <= 1'b0;
      bit_cnt <= NB_CNT;
    end else if (in_shift) begin
      if (div_tc) begin
        div_cnt <= DIV_LAST;
        phase   <= ~phase;
        if (phase) begin
          sreg    <= {sreg[NB-2:0], 1'b0};
          bit_cnt <= bit_cnt - BW'(1);
        end
      end else begin
        div_cnt <= div_cnt - DW'(1);
      end
    end else if (in_load) begin
      if (!div_tc) begin
        div_cnt <= div_cnt - DW'(1);
      end
    end
  end

  // Terminal-count events consumed by the top-level FSM.
  assign shift_end = in_shift & div_tc & phase & (bit_cnt == BW'(1));
  assign load_end  = in_load & div_tc;

  // Serial outputs are forced low outside their owning state.
  assign ser_clk  = in_shift & phase;
  assign ser_data = in_shift & sreg[NB-1];
  assign ser_load = in_load;

endmodule

// File: rtl/asic_iocfg.sv
// Pad configuration controller: host-writable shadow array and the
// sequencing FSM that pushes a snapshot of it down the pad serial chain.
//
//   state | meaning
//   IDLE  | accepting host writes, waiting for apply
//   SHIFT | shifting the snapshot out, pad N-1 first, MSB first
//   LOAD  | ser_load high for DIV cycles to latch the pad cells
//   DONE  | one-cycle done pulse, then back to IDLE
module asic_iocfg
  import asic_iocfg_pkg::*;
#(
  parameter int            N      = 8,
  parameter int            CW     = 13,
  parameter int            DIV    = 2,
  parameter logic [CW-1:0] DEFCFG = CW'(DEFCFG_RST)
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [clog2_min1(N)-1:0]   cfg_addr,
  input  logic [CW-1:0]              cfg_data,
  input  logic                       apply,
  output logic                       busy,
  output logic                       done,
  output logic [N*CW-1:0]            pad_cfg,
  output logic                       ser_clk,
  output logic                       ser_data,
  output logic                       ser_load
);

  localparam int AW = clog2_min1(N);

  iocfg_state_e  state;
  iocfg_state_e  state_nxt;
  logic [CW-1:0] shadow     [N];
  logic [CW-1:0] shadow_nxt [N];
  logic [N*CW-1:0] snap;
  logic          wr_en;
  logic          start;
  logic          shift_end;
  logic          load_end;

  assign busy      = (state != IDLE);
  assign cfg_ready = ~busy;
  assign done      = (state == DONE);
  assign wr_en     = cfg_valid & cfg_ready;
  assign start     = (state == IDLE) & apply;

  // Shadow array with this cycle's write merged in. Addresses >= N match no
  // entry, so such writes are accepted and simply dropped.
  always_comb begin
    shadow_nxt = shadow;
    for (int i = 0; i < N; i++) begin
      if (wr_en && (cfg_addr == AW'(i))) begin
        shadow_nxt[i] = cfg_data;
      end
    end
  end

  // Shadow registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < N; i++) begin
        shadow[i] <= DEFCFG;
      end
    end else begin
      shadow <= shadow_nxt;
    end
  end

  // Readback of the shadow array, and the snapshot (which includes a write
  // landing in the same cycle as apply).
  always_comb begin
    pad_cfg = '0;
    snap    = '0;
    for (int i = 0; i < N; i++) begin
      pad_cfg[i*CW +: CW] = shadow[i];
      snap[i*CW +: CW]    = shadow_nxt[i];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; apply outside IDLE is ignored.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (apply)     state_nxt = SHIFT;
      SHIFT: if (shift_end) state_nxt = LOAD;
      LOAD:  if (load_end)  state_nxt = DONE;
      DONE:                 state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  asic_iocfg_ser #(
    .N   (N),
    .CW  (CW),
    .DIV (DIV)
  ) u_ser (
    .clk       (clk),
    .nreset    (nreset),
    .state     (state),
    .start     (start),
    .snap      (snap),
    .shift_end (shift_end),
    .load_end  (load_end),
    .ser_clk   (ser_clk),
    .ser_data  (ser_data),
    .ser_load  (ser_load)
  );

endmodule

// File: tb/tb_asic_iocfg.sv
// Bench for asic_iocfg (N=4, CW=13, DIV=2) plus an N=6 instance for
// out-of-range address handling.
module tb_asic_iocfg;

  localparam int N   = 4;
  localparam int CW  = 13;
  localparam int DIV = 2;
  localparam int NB  = N * CW;
  localparam int SH  = 2 * DIV * NB;
  localparam int TOT = SH + DIV + 1;
  localparam logic [12:0] DEF = 13'h0403;

  logic          clk;
  logic          nreset;
  logic          cfg_valid;
  logic [1:0]    cfg_addr;
  logic [12:0]   cfg_data;
  logic          apply;
  logic          cfg_ready, busy, done, ser_clk, ser_data, ser_load;
  logic [NB-1:0] pad_cfg;

  logic          v6;
  logic [2:0]    a6;
  logic [12:0]   d6;
  logic          ap6;
  logic          r6, b6, dn6, sc6, sd6, sl6;
  logic [6*CW-1:0] pc6;

  int nchk = 0;
  int nerr = 0;

  logic [12:0]   m [N];
  logic [NB-1:0] last_got;

  asic_iocfg #(.N(N), .CW(CW), .DIV(DIV)) dut (
    .clk(clk), .nreset(nreset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .apply(apply), .busy(busy),
    .done(done), .pad_cfg(pad_cfg), .ser_clk(ser_clk), .ser_data(ser_data),
    .ser_load(ser_load)
  );

  asic_iocfg #(.N(6), .CW(CW), .DIV(DIV)) dut6 (
    .clk(clk), .nreset(nreset), .cfg_valid(v6), .cfg_ready(r6),
    .cfg_addr(a6), .cfg_data(d6), .apply(ap6), .busy(b6),
    .done(dn6), .pad_cfg(pc6), .ser_clk(sc6), .ser_data(sd6),
    .ser_load(sl6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] flat();
    logic [NB-1:0] v;
    for (int i = 0; i < N; i++) v[i*CW +: CW] = m[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m[i] = DEF;
  endtask

  task automatic wr(input logic [1:0] a, input logic [12:0] d);
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    chk("wr_ready", cfg_ready, 1'b1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    m[a] = d;
    @(negedge clk);
    chk("wr_pad", pad_cfg, flat());
  endtask

  // One apply and the full transfer window, checked cycle by cycle against
  // the bit-period arithmetic. Optional write in the apply cycle, optional
  // write+apply injected mid-shift, optional reset abort at cycle abort_k.
  task automatic xfer(input bit co_wr, input logic [12:0] co_data,
                      input int inj_k, input int abort_k);
    logic [NB-1:0] exp_v;
    logic [NB-1:0] got;
    int shape_err, loads, dones, nbits, done_k, bi;
    logic prev_clk, e_clk, e_dat, e_ld, e_done, e_busy;
    shape_err = 0; loads = 0; dones = 0; nbits = 0; done_k = -1;
    prev_clk = 1'b0; got = '0;
    @(posedge clk); #1;
    apply = 1'b1;
    if (co_wr) begin
      cfg_valid = 1'b1; cfg_addr = 2'd0; cfg_data = co_data; m[0] = co_data;
    end
    exp_v = flat();
    @(posedge clk); #1;
    apply = 1'b0; cfg_valid = 1'b0;
    for (int k = 1; k <= TOT + 1; k++) begin
      @(negedge clk);
      if (k == abort_k) begin
        nreset = 1'b0;
        #1;
        model_reset();
        chk("abort_pad", pad_cfg, flat());
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", cfg_ready, 1'b1);
        chk("abort_ser", {ser_clk, ser_data, ser_load, done}, 4'b0000);
        chk("abort_noload", loads, 0);
        chk("abort_shape", shape_err, 0);
        @(negedge clk);
        nreset = 1'b1;
        return;
      end
      if (k <= SH) begin
        bi = (k - 1) / (2 * DIV);
        e_clk = (((k - 1) % (2 * DIV)) >= DIV);
        e_dat = exp_v[NB-1-bi];
        e_ld = 1'b0; e_done = 1'b0; e_busy = 1'b1;
      end else if (k <= SH + DIV) begin
        e_clk = 1'b0; e_dat = 1'b0; e_ld = 1'b1; e_done = 1'b0; e_busy = 1'b1;
      end else if (k == TOT) begin
        e_clk = 1'b0; e_dat = 1'b0; e_ld = 1'b0; e_done = 1'b1; e_busy = 1'b1;
      end else begin
        e_clk = 1'b0; e_dat = 1'b0; e_ld = 1'b0; e_done = 1'b0; e_busy = 1'b0;
      end
      if ({ser_clk, ser_data, ser_load, done, busy, cfg_ready} !==
          {e_clk, e_dat, e_ld, e_done, e_busy, ~e_busy})
        shape_err++;
      if (ser_clk && !prev_clk && nbits < NB) begin
        got[NB-1-nbits] = ser_data;
        nbits++;
      end
      prev_clk = ser_clk;
      if (ser_load) loads++;
      if (done) begin dones++; done_k = k; end
      if (k == inj_k) begin
        chk("inj_ready", cfg_ready, 1'b0);
        cfg_valid = 1'b1; cfg_addr = 2'd1; cfg_data = ~m[1]; apply = 1'b1;
      end
      if (k == inj_k + 1) begin
        cfg_valid = 1'b0; apply = 1'b0;
      end
    end
    last_got = got;
    chk("shape", shape_err, 0);
    chk("nbits", nbits, NB);
    chk("bits", got, exp_v);
    chk("load_cycles", loads, DIV);
    chk("done_pulses", dones, 1);
    chk("done_cycle", done_k, TOT);
    chk("pad_after", pad_cfg, flat());
  endtask

  initial begin
    cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; apply = 1'b0;
    v6 = 1'b0; a6 = '0; d6 = '0; ap6 = 1'b0;
    nreset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pad", pad_cfg, flat());
    chk("rst_busy", busy, 1'b0);
    chk("rst_ser", {ser_clk, ser_data, ser_load, done}, 4'b0000);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    chk("rel_ready", cfg_ready, 1'b1);

    // N=6: out-of-range address accepted and dropped, in-range write lands.
    @(posedge clk); #1;
    v6 = 1'b1; a6 = 3'd7; d6 = 13'h1FFF;
    @(negedge clk);
    chk("n6_ready", r6, 1'b1);
    @(posedge clk); #1;
    v6 = 1'b0;
    @(negedge clk);
    chk("n6_addr7", pc6, {6{DEF}});
    @(posedge clk); #1;
    v6 = 1'b1; a6 = 3'd5; d6 = 13'h0155;
    @(posedge clk); #1;
    v6 = 1'b0;
    @(negedge clk);
    chk("n6_addr5", pc6, {13'h0155, {5{DEF}}});

    // Directed: pad2 pattern lands at bits 13..25.
    wr(2'd2, 13'h1ABC);
    xfer(1'b0, 13'h0, 0, 0);
    chk("pad2_bits", last_got[NB-1-13 -: 13], 13'h1ABC);

    // Write in the apply cycle is part of the snapshot.
    xfer(1'b1, 13'h0001, 0, 0);
    chk("last13", last_got[12:0], 13'h0001);

    // Write and apply during SHIFT are refused/ignored.
    xfer(1'b0, 13'h0, 30, 0);

    // Randomized writes and transfers.
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 4; w++) begin
        wr(2'($urandom_range(0, 3)), 13'($urandom));
      end
      xfer(1'($urandom_range(0, 1)), 13'($urandom), 0, 0);
    end

    // Reset at the start of bit 20, then a clean full transfer.
    wr(2'd3, 13'h0AAA);
    xfer(1'b0, 13'h0, 0, 20 * 2 * DIV + 1);
    wr(2'd1, 13'h1357);
    xfer(1'b0, 13'h0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/asic_iocfg.md
ASIC_IOCFG -- requirements
Module: asic_iocfg

Interface
REQ-001 SHALL have parameter N, default 8: number of configurable pads in the padring.
REQ-002 SHALL have parameter CW, default 13: configuration bits per pad.
REQ-003 SHALL have parameter DIV, default 2: clk cycles per ser_clk half-period, >=1.
REQ-004 SHALL have parameter DEFCFG, default 13'h0403: per-pad configuration reset value.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (sole clock) and nreset input 1.
REQ-006 SHALL have cfg_valid input 1: host write request.
REQ-007 SHALL have cfg_ready output 1: write accepted when cfg_valid & cfg_ready.
REQ-008 SHALL have cfg_addr input $clog2(N): pad index.
REQ-009 SHALL have cfg_data input CW: configuration word.
REQ-010 SHALL have apply input 1: single-cycle request to push all shadow words to the pads.
REQ-011 SHALL have busy output 1: serial transfer in progress.
REQ-012 SHALL have done output 1: one-cycle pulse at transfer end.
REQ-013 SHALL have pad_cfg output N*CW: shadow register readback, pad i at [i*CW +: CW].
REQ-014 SHALL have ser_clk, ser_data and ser_load outputs, each 1: serial chain into pad control cells.

Function
REQ-015 SHALL use states IDLE, SHIFT, LOAD, DONE.
REQ-016 In IDLE: cfg_ready=1; an accepted write updates shadow[cfg_addr] at the next clk edge.
REQ-017 A write with cfg_addr>=N SHALL be accepted and discarded.
REQ-018 apply in IDLE SHALL move to SHIFT the next cycle and snapshot all shadow words, including any write accepted in the apply cycle.
REQ-019 SHIFT SHALL send N*CW bits: pad N-1 first, MSB first within each word.
REQ-020 Each bit SHALL last 2*DIV cycles: ser_data stable for the whole bit, ser_clk low for DIV cycles then high for DIV cycles.
REQ-021 After the last bit, LOAD SHALL drive ser_load=1 and ser_clk=0 for DIV cycles, then go to DONE.
REQ-022 DONE SHALL last one cycle: done=1, then return to IDLE.
REQ-023 busy SHALL be 1 in SHIFT, LOAD and DONE; cfg_ready SHALL equal !busy.
REQ-024 Total latency SHALL be 2*DIV*N*CW+DIV+1 cycles from the first SHIFT cycle to the end of DONE.
REQ-025 apply while busy SHALL be ignored, not queued.
REQ-026 Writes while busy SHALL be refused (cfg_ready=0), shadow unchanged.
REQ-027 ser_data SHALL be 0 outside SHIFT; ser_load SHALL be 0 outside LOAD.
REQ-028 The bit counter SHALL be $clog2(N*CW+1) wide with no wrap; the divider counter SHALL be $clog2(DIV) wide (min 1).

Reset
REQ-029 On nreset low, asynchronously: state=IDLE, every shadow word=DEFCFG, ser_clk=ser_data=ser_load=0, busy=done=0, cfg_ready=1 from release.
REQ-030 Reset mid-transfer SHALL abort with no ser_load pulse; pads keep their previous latched configuration.
REQ-031 Release SHALL be synchronised upstream; the block adds no reset synchroniser.

Structure
REQ-032 Package asic_iocfg_pkg SHALL hold the state enum and the default DEFCFG constant.
REQ-033 Sub-module asic_iocfg_ser (snapshot shift register, divider, bit counter, ser_* generation) SHALL be instantiated once; the top holds the shadow array, FSM and host handshake.

Verification (N=4, CW=13, DIV=2)
REQ-034 Reset: nreset low mid-run -> pad_cfg=4x13'h0403, busy=0, cfg_ready=1, ser_*=0.
REQ-035 Write pad2=13'h1ABC, then apply -> 52 bits; bits 13..25 = 1_1010_1011_1100; ser_load high 2 cycles; done at cycle 211 after SHIFT entry; busy low next cycle.
REQ-036 apply and write pad0=13'h0001 in the same cycle -> the last 13 bits shifted are 0000000000001.
REQ-037 Write plus second apply during SHIFT -> cfg_ready=0, shadow unchanged, exactly one done pulse.
REQ-038 nreset low at bit 20 -> all outputs reset, no ser_load; a new apply runs a full 52-bit transfer.
REQ-039 N=6, write addr 7 -> accepted, pad_cfg unchanged.
